// File: rtl/proc_control_pkg.sv
// proc_control_pkg
//   Shared definitions for the 9-bit multicycle processor control unit:
//   instruction width, opcode constants, the time-step state type and
//   instruction field helpers.
package proc_control_pkg;

   localparam int DW = 9;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_MVNZ = 3'b110;

   typedef enum logic [1:0] {
      T0 = 2'b00,
      T1 = 2'b01,
      T2 = 2'b10,
      T3 = 2'b11
   } tstep_t;

   function automatic logic [2:0] ir_op(input logic [DW-1:0] ir);
      return ir[8:6];
   endfunction

   function automatic logic [2:0] ir_x(input logic [DW-1:0] ir);
      return ir[5:3];
   endfunction

   function automatic logic [2:0] ir_y(input logic [DW-1:0] ir);
      return ir[2:0];
   endfunction

endpackage

// File: rtl/proc_control_dec3to8.sv
// dec3to8
//   3-to-8 register decoder. Register index k sets bit 7-k of Y when En=1.
// Ports
//   W  in  3  register index
//   En in  1  decoder enable
//   Y  out 8  one-hot select (all zero when En=0)
module dec3to8 (
   input  logic [2:0] W,
   input  logic       En,
   output logic [7:0] Y
);

   always_comb begin
      Y = '0;
      if (En) Y[3'd7 - W] = 1'b1;
   end

endmodule

// File: rtl/proc_control.sv
// proc_control
//   Control unit of the 9-bit multicycle processor. Captures the
//   instruction word from DIN, steps through T0..T3 and decodes the
//   datapath control lines from the current step and IR.
// Ports
//   Clock, Resetn          clock (rising edge), async active-low reset
//   Run                    start request, only looked at in T0
//   DIN [DW-1:0]           instruction word / immediate
//   GNZ                    G-register non-zero flag (mvnz condition)
//   IR  [DW-1:0]           instruction register
//   IRin                   IR load enable
//   Rin/Rout [7:0]         register load / bus-drive one-hot (bit 7-k = Rk)
//   DINout, Gout           DIN / G drive the bus
//   Ain, Gin, AddSub       A load, G load, ALU subtract select
//   Done                   final step of the current instruction
//   Tstep [1:0]            current time step (debug visibility)
//
// Run/IRin handshake: Run is a level request. It is accepted on the rising
// edge ending any T0 cycle in which Run=1 (IRin=1 in that cycle); the
// instruction on DIN is captured on that same edge. Run is ignored in
// T1..T3, so there is no separate ready signal: Done marks the last step
// and the following cycle is T0, ready for the next request.
module proc_control
   import proc_control_pkg::*;
#(
   parameter int DW = proc_control_pkg::DW
) (
   input  logic          Clock,
   input  logic          Resetn,
   input  logic          Run,
   input  logic [DW-1:0] DIN,
   input  logic          GNZ,
   output logic [DW-1:0] IR,
   output logic          IRin,
   output logic [7:0]    Rin,
   output logic [7:0]    Rout,
   output logic          DINout,
   output logic          Gout,
   output logic          Ain,
   output logic          Gin,
   output logic          AddSub,
   output logic          Done,
   output logic [1:0]    Tstep
);

   tstep_t        tstep_q, tstep_d;
   logic [DW-1:0] ir_q, ir_d;

   logic [7:0] x_onehot, y_onehot;
   logic       rin_x, rout_x, rout_y;
   logic [2:0] op;

   dec3to8 u_dec_x (.W(ir_x(ir_q)), .En(1'b1), .Y(x_onehot));
   dec3to8 u_dec_y (.W(ir_y(ir_q)), .En(1'b1), .Y(y_onehot));

   assign op = ir_op(ir_q);

   always_comb begin
      tstep_d = tstep_q;
      IRin    = 1'b0;
      rin_x   = 1'b0;
      rout_x  = 1'b0;
      rout_y  = 1'b0;
      DINout  = 1'b0;
      Gout    = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      AddSub  = 1'b0;
      Done    = 1'b0;

      unique case (tstep_q)
         T0: begin
            // Gated so nothing is reported as accepted while held in reset.
            IRin = Run & Resetn;
            if (Run) tstep_d = T1;
         end
         T1: begin
            tstep_d = T0;
            case (op)
               OP_MV: begin
                  rout_y = 1'b1;
                  rin_x  = 1'b1;
                  Done   = 1'b1;
               end
               OP_MVI: begin
                  DINout = 1'b1;
                  rin_x  = 1'b1;
                  Done   = 1'b1;
               end
               OP_ADD, OP_SUB: begin
                  rout_x  = 1'b1;
                  Ain     = 1'b1;
                  tstep_d = T2;
               end
               OP_MVNZ: begin
                  rout_y = GNZ;
                  rin_x  = GNZ;
                  Done   = 1'b1;
               end
               default: Done = 1'b1;
            endcase
         end
         T2: begin
            rout_y  = 1'b1;
            Gin     = 1'b1;
            AddSub  = (op == OP_SUB);
            tstep_d = T3;
         end
         T3: begin
            Gout    = 1'b1;
            rin_x   = 1'b1;
            Done    = 1'b1;
            tstep_d = T0;
         end
         default: tstep_d = T0;
      endcase

      Rin  = x_onehot & {8{rin_x}};
      Rout = (x_onehot & {8{rout_x}}) | (y_onehot & {8{rout_y}});
      ir_d = IRin ? DIN : ir_q;
   end

   always_ff @(posedge Clock or negedge Resetn) begin
      if (!Resetn) begin
         tstep_q <= T0;
         ir_q    <= '0;
      end else begin
         tstep_q <= tstep_d;
         ir_q    <= ir_d;
      end
   end

   assign IR    = ir_q;
   assign Tstep = tstep_q;

endmodule

// File: tb/tb_proc_control.sv
// tb_proc_control
//   Bench for proc_control: directed instruction sequences followed by
//   random instructions, checked cycle by cycle against an instruction-level
//   reference model that lists the expected control bundle of every step.
module tb_proc_control;

   logic       Clock;
   logic       Resetn;
   logic       Run;
   logic [8:0] DIN;
   logic       GNZ;
   logic [8:0] IR;
   logic       IRin;
   logic [7:0] Rin;
   logic [7:0] Rout;
   logic       DINout;
   logic       Gout;
   logic       Ain;
   logic       Gin;
   logic       AddSub;
   logic       Done;
   logic [1:0] Tstep;

   proc_control dut (
      .Clock  (Clock),
      .Resetn (Resetn),
      .Run    (Run),
      .DIN    (DIN),
      .GNZ    (GNZ),
      .IR     (IR),
      .IRin   (IRin),
      .Rin    (Rin),
      .Rout   (Rout),
      .DINout (DINout),
      .Gout   (Gout),
      .Ain    (Ain),
      .Gin    (Gin),
      .AddSub (AddSub),
      .Done   (Done),
      .Tstep  (Tstep)
   );

   // ---------------- clock / reset ----------------
   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   // Observed bundle: {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done}
   logic [22:0] out_vec;
   assign out_vec = {IRin, Rin, Rout, DINout, Gout, Ain, Gin, AddSub, Done};

   // ---------------- scoreboard ----------------
   logic [22:0] exp_q[$];
   int          vectors;
   int          miscompares;
   logic [8:0]  model_ir;

   function automatic logic [22:0] pk(input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic dinout,
                                      input logic gout, input logic ain,
                                      input logic gin, input logic addsub,
                                      input logic done);
      return {irin, rin, rout, dinout, gout, ain, gin, addsub, done};
   endfunction

   // Register k maps to bit 7-k.
   function automatic logic [7:0] reg_sel(input int k);
      return 8'h80 >> k;
   endfunction

   // Instruction-level reference: expected bundle for each step after accept.
   task automatic model_instr(input logic [8:0] instr, input logic gnz);
      int op, x, y;
      op = int'(instr[8:6]);
      x  = int'(instr[5:3]);
      y  = int'(instr[2:0]);
      case (op)
         0: exp_q.push_back(pk(0, reg_sel(x), reg_sel(y), 0, 0, 0, 0, 0, 1));
         1: exp_q.push_back(pk(0, reg_sel(x), 8'h00, 1, 0, 0, 0, 0, 1));
         2, 3: begin
            exp_q.push_back(pk(0, 8'h00, reg_sel(x), 0, 0, 1, 0, 0, 0));
            exp_q.push_back(pk(0, 8'h00, reg_sel(y), 0, 0, 0, 1, (op == 3), 0));
            exp_q.push_back(pk(0, reg_sel(x), 8'h00, 0, 1, 0, 0, 0, 1));
         end
         6: begin
            if (gnz) exp_q.push_back(pk(0, reg_sel(x), reg_sel(y), 0, 0, 0, 0, 0, 1));
            else     exp_q.push_back(pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
         end
         default: exp_q.push_back(pk(0, 8'h00, 8'h00, 0, 0, 0, 0, 0, 1));
      endcase
   endtask

   task automatic cmp_now(input logic [22:0] exp_out, input logic [1:0] exp_t,
                          input logic [8:0] exp_ir, input string tag);
      vectors++;
      assert (out_vec === exp_out) else begin
         miscompares++;
         $error("FAIL %s outputs: observed %h expected %h", tag, out_vec, exp_out);
      end
      vectors++;
      assert (Tstep === exp_t) else begin
         miscompares++;
         $error("FAIL %s tstep: observed %0d expected %0d", tag, Tstep, exp_t);
      end
      vectors++;
      assert (IR === exp_ir) else begin
         miscompares++;
         $error("FAIL %s ir: observed %h expected %h", tag, IR, exp_ir);
      end
   endtask

   // Inputs are already applied; check at the falling edge, then move to
   // just after the next rising edge.
   task automatic check_cycle(input logic [22:0] exp_out, input logic [1:0] exp_t,
                              input string tag);
      @(negedge Clock);
      cmp_now(exp_out, exp_t, model_ir, tag);
      @(posedge Clock);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic idle_cycle(input string tag);
      Run = 1'b0;
      DIN = 9'($urandom_range(0, 511));
      GNZ = 1'($urandom_range(0, 1));
      check_cycle('0, 2'd0, tag);
   endtask

   task automatic do_instr(input logic [8:0] instr, input logic gnz, input string tag);
      int k;
      Run = 1'b1;
      DIN = instr;
      GNZ = 1'($urandom_range(0, 1));
      check_cycle(pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), 2'd0, tag);
      model_ir = instr;
      model_instr(instr, gnz);
      k = 1;
      while (exp_q.size() > 0) begin
         Run = 1'($urandom_range(0, 1));
         DIN = (instr[8:6] == 3'b001 && k == 1) ? 9'h005 : 9'($urandom_range(0, 511));
         GNZ = gnz;
         check_cycle(exp_q.pop_front(), 2'(k), tag);
         k++;
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      vectors     = 0;
      miscompares = 0;
      model_ir    = '0;
      Resetn      = 1'b0;
      Run         = 1'b1;
      DIN         = 9'h1A5;
      GNZ         = 1'b0;

      // Reset held with Run=1: everything quiet, IRin gated.
      #2;
      check_cycle('0, 2'd0, "reset_hold");
      Resetn = 1'b1;
      // First edge after release accepts mvnz R4,R5 (GNZ=0).
      do_instr(9'h1A5, 1'b0, "first_accept_mvnz_gnz0");

      do_instr(9'h050, 1'b0, "mvi_r2");
      do_instr(9'h08B, 1'b0, "add_r1_r3");
      do_instr(9'h0F8, 1'b0, "sub_r7_r0");
      do_instr(9'h1A5, 1'b1, "mvnz_gnz1");
      do_instr(9'h00E, 1'b0, "mv_r1_r6");
      do_instr(9'h13F, 1'b1, "reserved_100");
      idle_cycle("idle");

      // Reset pulsed during T2 of an add.
      Run = 1'b1;
      DIN = 9'h08B;
      check_cycle(pk(1, 8'h00, 8'h00, 0, 0, 0, 0, 0, 0), 2'd0, "midreset_t0");
      model_ir = 9'h08B;
      Run = 1'b1;
      check_cycle(pk(0, 8'h00, reg_sel(1), 0, 0, 1, 0, 0, 0), 2'd1, "midreset_t1");
      #1;
      Resetn = 1'b0;
      model_ir = '0;
      #1;
      cmp_now('0, 2'd0, model_ir, "midreset_immediate");
      check_cycle('0, 2'd0, "midreset_held");
      Resetn = 1'b1;
      idle_cycle("midreset_no_done");

      // Random instruction stream with occasional idle T0 cycles.
      for (int i = 0; i < 60; i++) begin
         if ($urandom_range(0, 3) == 0) idle_cycle("rand_idle");
         do_instr(9'($urandom_range(0, 511)), 1'($urandom_range(0, 1)), "rand_instr");
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   // Absolute bound so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
